counter_checker: RTL
====================

Name: counter_checker

Overview:
- Receiving end of the free-running counter stream: samples a WIDTH-bit counter value and checks that each sample is the previous sample plus one, modulo 2^WIDTH.
- Acquires lock after a run of consecutive correct samples, flags every sequence break while locked, and keeps a saturating error tally.
- Sits downstream of any up-counter output, including across a slow or gapped link, as a self-check / link monitor.

Parameters:
- WIDTH, 4, width of the monitored counter value.
- LOCK_COUNT, 3, consecutive matching samples in ACQUIRE needed to assert lock; must be >= 1.
- UNLOCK_COUNT, 2, consecutive mismatching samples in LOCKED that drop lock; must be >= 1.
- ERR_W, 8, width of the error tally.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_value is a sample this cycle.
- in_value  input  WIDTH  counter value under test.
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED state.
- err  output  1  one-cycle pulse: a sample mismatched while LOCKED.
- err_count  output  ERR_W  saturating count of err pulses.
- expected  output  WIDTH  value the next sample must equal.

Behaviour:
- Reset: state IDLE; locked=0, err=0, err_count=0, expected=0; internal good_run=0, bad_run=0. rst has priority over all other inputs, including mid-LOCKED.
- All outputs are registered and update on the edge that samples in_valid=1; they are visible the following cycle. Latency is 1 clock from sample to err/locked.
- in_valid=0: state, runs, expected and err_count hold; err=0.
- err is 0 in every cycle except the one after a LOCKED mismatch.
- Match is defined as in_value == expected. Arithmetic is mod 2^WIDTH, so expected 0 after sample 2^WIDTH-1 and 15->0 (WIDTH=4) is a match.
- IDLE, on valid: expected <= in_value+1; good_run <= 0; go to ACQUIRE. The first sample is never checked.
- ACQUIRE, on valid, no errors flagged:
  - Match: good_run++. If good_run+1 == LOCK_COUNT, go to LOCKED and set bad_run <= 0.
  - Mismatch: good_run <= 0.
  - Either case: expected <= in_value+1 (resync).
- LOCKED, on valid:
  - Match: bad_run <= 0; expected <= expected+1.
  - Mismatch: err <= 1; err_count saturating +1; bad_run++; expected <= in_value+1 (resync, so a single skip costs exactly one error). If bad_run+1 == UNLOCK_COUNT, go to ACQUIRE with good_run <= 0.
  - locked tracks the state: 1 exactly while in LOCKED.
- err_count:
  - Saturates at 2^ERR_W-1 and never wraps.
  - clr_count alone sets it to 0.
  - clr_count in the same cycle as a LOCKED mismatch sets it to 1.
  - clr_count does not affect state.

Test Plan:
- Lock and wrap (WIDTH=4, LOCK_COUNT=3): rst, then in_valid=1 every cycle with values 0..15,0..3 -> locked=1 starting the cycle after sample 3, stays 1 through 15->0; err never 1; err_count=0.
- Single skip (UNLOCK_COUNT=2): while locked, send 5,6,9,10,11 -> err=1 for exactly one cycle after 9; err_count=1; locked stays 1; expected=10 after 9, 12 after 11.
- Loss and reacquire: while locked, send 5,6,9,2,3,4,5 -> err pulses after 9 and after 2; err_count=2; locked=0 after 2; locked=1 again after 5, with no further err.
- Gapped stream: while locked, send 6, hold in_valid=0 for 5 cycles with in_value=0, then send 7 -> no err; expected holds at 7 during the gap; locked stays 1.
- Saturation and clear (ERR_W=2): while locked, force 5 isolated mismatches -> err_count reads 1,2,3,3,3. Then clr_count together with a mismatch -> err_count=1. Then clr_count alone -> err_count=0.
- Reset mid-operation: while locked with err_count=2, assert rst one cycle -> next cycle locked=0, err=0, err_count=0, expected=0. Next valid sample 9 -> no err; expected=10.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker
//   Link monitor for a free-running up-counter stream. Each valid sample is
//   compared with the previous sample plus one, modulo 2^WIDTH. After
//   LOCK_COUNT consecutive matches the checker declares lock. While locked,
//   every break in the sequence pulses err and bumps a saturating tally.
//   UNLOCK_COUNT consecutive breaks drop the checker back to acquisition.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   in_valid   in_value carries a sample this cycle
//   in_value   counter value under test
//   clr_count  synchronous clear of err_count
//   locked     1 while the checker is in the LOCKED state
//   err        one-cycle pulse after a mismatch seen while LOCKED
//   err_count  saturating count of err pulses
//   expected   value the next sample must equal
module counter_checker #(
    parameter int WIDTH        = 4,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 2,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_value,
    input  logic             clr_count,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    // Run counters only ever need to reach their thresholds; comparing with
    // threshold-1 lets the transition fire on the sample that completes the run.
    localparam logic [GW-1:0]    LOCK_LAST   = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]    UNLOCK_LAST = BW'(UNLOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t           state_q, state_n;
    logic [GW-1:0]    good_run_q, good_run_n;
    logic [BW-1:0]    bad_run_q, bad_run_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic             err_q, err_n;
    logic [ERR_W-1:0] cnt_q, cnt_n;
    logic             match;
    logic             lock_miss;

    assign match     = (in_value == exp_q);
    assign lock_miss = (state_q == LOCKED) && in_valid && !match;

    // Next-state logic. Every register holds by default; only a valid sample
    // moves the FSM. A mismatch always resyncs expected to the observed value
    // so that one skipped value costs exactly one error rather than a burst.
    always_comb begin
        state_n    = state_q;
        good_run_n = good_run_q;
        bad_run_n  = bad_run_q;
        exp_n      = exp_q;
        err_n      = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    exp_n      = in_value + WIDTH'(1);
                    good_run_n = '0;
                    state_n    = ACQUIRE;
                end
                ACQUIRE: begin
                    exp_n = in_value + WIDTH'(1);
                    if (match) begin
                        good_run_n = good_run_q + GW'(1);
                        if (good_run_q == LOCK_LAST) begin
                            state_n   = LOCKED;
                            bad_run_n = '0;
                        end
                    end else begin
                        good_run_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_run_n = '0;
                        exp_n     = exp_q + WIDTH'(1);
                    end else begin
                        err_n     = 1'b1;
                        bad_run_n = bad_run_q + BW'(1);
                        exp_n     = in_value + WIDTH'(1);
                        if (bad_run_q == UNLOCK_LAST) begin
                            state_n    = ACQUIRE;
                            good_run_n = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Error tally. A clear coinciding with a locked mismatch keeps that
    // mismatch, so the tally restarts at one instead of losing the event.
    always_comb begin
        cnt_n = cnt_q;
        if (clr_count) begin
            cnt_n = lock_miss ? ERR_W'(1) : '0;
        end else if (lock_miss && (cnt_q != ERR_MAX)) begin
            cnt_n = cnt_q + ERR_W'(1);
        end
    end

    // State register; reset wins over everything including clr_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            good_run_q <= '0;
            bad_run_q  <= '0;
            exp_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_n;
            good_run_q <= good_run_n;
            bad_run_q  <= bad_run_n;
            exp_q      <= exp_n;
            err_q      <= err_n;
            cnt_q      <= cnt_n;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_count = cnt_q;
    assign expected  = exp_q;

endmodule
